dual_request_dispatcher: RTL and testbench

//  Collects sticky request pulses from N requesters into a pending vector.

---
 rtl/dispatch_pkg.sv | 13 +
 rtl/dual_priority_encoder.sv | 32 +++
 rtl/dual_request_dispatcher.sv | 97 +++++++++
 tb/tb_dual_request_dispatcher.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared helpers for the request dispatcher.
package dispatch_pkg;

  // Widest request vector the helper below can inspect; callers zero-extend.
  localparam int MAX_N = 64;

  // True when two or more bits of v are set. Clearing the lowest set bit
  // leaves something behind only if a second bit was present.
  function automatic logic at_least_two(input logic [MAX_N-1:0] v);
    return |(v & (v - 64'd1));
  endfunction

endpackage

// File: rtl/dual_priority_encoder.sv
// Highest and next-highest set bit of a request vector.
// There is no valid output: with fewer than two bits set, the unused
// result(s) read as zero and the caller must qualify them.
module dual_priority_encoder #(
  parameter int N = 12,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] first_idx_o,
  output logic [IW-1:0] second_idx_o
);

  logic [IW-1:0] first_idx;
  logic [IW-1:0] second_idx;

  // Ascending scans: the last hit is the highest index. The second scan
  // skips the winner of the first.
  always_comb begin
    first_idx  = '0;
    second_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) first_idx = IW'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (IW'(i) != first_idx)) second_idx = IW'(i);
    end
  end

  assign first_idx_o  = first_idx;
  assign second_idx_o = second_idx;

endmodule

// File: rtl/dual_request_dispatcher.sv
// Sticky request collector draining up to two grants per cycle onto two
// independent valid/ready grant channels.
module dual_request_dispatcher
  import dispatch_pkg::*;
#(
  parameter int N = 12,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_set_i,
  output logic [N-1:0]  pend_o,
  output logic          g0_valid_o,
  output logic [IW-1:0] g0_idx_o,
  input  logic          g0_ready_i,
  output logic          g1_valid_o,
  output logic [IW-1:0] g1_idx_o,
  input  logic          g1_ready_i,
  output logic          merged_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]  pend_q, pend_d;
  logic          g0_valid_q, g0_valid_d;
  logic [IW-1:0] g0_idx_q, g0_idx_d;
  logic          g1_valid_q, g1_valid_d;
  logic [IW-1:0] g1_idx_q, g1_idx_d;
  logic          merged_q, merged_d;

  logic [IW-1:0] first_idx, second_idx;
  logic          have_first, have_second;
  logic          ch0_free, ch1_free;
  logic          load0, load1;
  logic [IW-1:0] g1_load_idx;
  logic [N-1:0]  loaded_mask;

  dual_priority_encoder #(.N(N)) u_enc (
    .req_i        (pend_q),
    .first_idx_o  (first_idx),
    .second_idx_o (second_idx)
  );

  assign have_first  = |pend_q;
  assign have_second = at_least_two(MAX_N'(pend_q));
  assign ch0_free    = !g0_valid_q || g0_ready_i;
  assign ch1_free    = !g1_valid_q || g1_ready_i;

  // Hand candidates to free channels in order: ch0 takes the top request,
  // ch1 takes the runner-up when ch0 also loads, else the top request.
  always_comb begin
    load0       = ch0_free && have_first;
    load1       = ch1_free && (ch0_free ? have_second : have_first);
    g1_load_idx = ch0_free ? second_idx : first_idx;
    loaded_mask = '0;
    if (load0) loaded_mask = loaded_mask | (ONE << first_idx);
    if (load1) loaded_mask = loaded_mask | (ONE << g1_load_idx);
  end

  // Next state: a free channel either loads or empties; a stalled one holds.
  // A same-cycle set re-arms a bit even if it is being loaded right now.
  always_comb begin
    g0_valid_d = ch0_free ? load0 : g0_valid_q;
    g0_idx_d   = load0 ? first_idx : g0_idx_q;
    g1_valid_d = ch1_free ? load1 : g1_valid_q;
    g1_idx_d   = load1 ? g1_load_idx : g1_idx_q;
    pend_d     = (pend_q & ~loaded_mask) | req_set_i;
    merged_d   = |(req_set_i & pend_q & ~loaded_mask);
  end

  // State registers; reset discards pending and in-flight grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      g0_valid_q <= 1'b0;
      g0_idx_q   <= '0;
      g1_valid_q <= 1'b0;
      g1_idx_q   <= '0;
      merged_q   <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      g0_valid_q <= g0_valid_d;
      g0_idx_q   <= g0_idx_d;
      g1_valid_q <= g1_valid_d;
      g1_idx_q   <= g1_idx_d;
      merged_q   <= merged_d;
    end
  end

  assign pend_o     = pend_q;
  assign g0_valid_o = g0_valid_q;
  assign g0_idx_o   = g0_idx_q;
  assign g1_valid_o = g1_valid_q;
  assign g1_idx_o   = g1_idx_q;
  assign merged_o   = merged_q;

endmodule

// File: tb/tb_dual_request_dispatcher.sv
// Self-checking bench for dual_request_dispatcher (N = 12).
module tb_dual_request_dispatcher;

  localparam int N  = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_set_i;
  logic [N-1:0]  pend_o;
  logic          g0_valid_o, g1_valid_o, g0_ready_i, g1_ready_i, merged_o;
  logic [IW-1:0] g0_idx_o, g1_idx_o;

  dual_request_dispatcher #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_set_i  (req_set_i),
    .pend_o     (pend_o),
    .g0_valid_o (g0_valid_o),
    .g0_idx_o   (g0_idx_o),
    .g0_ready_i (g0_ready_i),
    .g1_valid_o (g1_valid_o),
    .g1_idx_o   (g1_idx_o),
    .g1_ready_i (g1_ready_i),
    .merged_o   (merged_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending set and two channel slots.
  logic [N-1:0]  m_pend = '0;
  logic          m_v0 = 0, m_v1 = 0, m_m = 0;
  logic [IW-1:0] m_i0 = '0, m_i1 = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance the model one clock from the current inputs: list pending
  // indices from highest down and deal them out to free channels in order.
  task automatic model_advance();
    int cand[$];
    int ci;
    logic [N-1:0] mask;
    logic f0, f1;
    if (rst) begin
      m_pend = '0; m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0; m_m = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) cand.push_back(i);
    f0 = !m_v0 || g0_ready_i;
    f1 = !m_v1 || g1_ready_i;
    ci = 0;
    mask = '0;
    if (f0) begin
      if (ci < cand.size()) begin
        m_v0 = 1; m_i0 = IW'(cand[ci]); mask[cand[ci]] = 1'b1; ci++;
      end else m_v0 = 0;
    end
    if (f1) begin
      if (ci < cand.size()) begin
        m_v1 = 1; m_i1 = IW'(cand[ci]); mask[cand[ci]] = 1'b1; ci++;
      end else m_v1 = 0;
    end
    m_m    = |(req_set_i & m_pend & ~mask);
    m_pend = (m_pend & ~mask) | req_set_i;
  endtask

  // One clock: update model, clock DUT, compare the whole output tuple.
  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    n_checks++;
    if ({pend_o, g0_valid_o, g0_idx_o, g1_valid_o, g1_idx_o, merged_o} !==
        {m_pend, m_v0, m_i0, m_v1, m_i1, m_m}) begin
      n_fail++;
      $display("FAIL model t=%0t: got pend=%h g0=(%0b,%0d) g1=(%0b,%0d) m=%0b expected pend=%h g0=(%0b,%0d) g1=(%0b,%0d) m=%0b",
               $time, pend_o, g0_valid_o, g0_idx_o, g1_valid_o, g1_idx_o, merged_o,
               m_pend, m_v0, m_i0, m_v1, m_i1, m_m);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          r0, r1;
    logic [N-1:0]  e_pend;
    logic          e_v0;
    logic [IW-1:0] e_i0;
    logic          e_v1;
    logic [IW-1:0] e_i1;
    logic          e_m;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Reset hold with all requests asserted, release, then the 0x009 pair.
    vecs[0] = '{1'b1, 12'hFFF, 1'b1, 1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 12'hFFF, 1'b1, 1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 12'hFFF, 1'b1, 1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[4] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[5] = '{1'b0, 12'h009, 1'b1, 1'b1, 12'h009, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0};
    vecs[6] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0};
    vecs[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b0, 4'd3, 1'b0, 4'd0, 1'b0};

    rst = 1'b1; req_set_i = '0; g0_ready_i = 1'b1; g1_ready_i = 1'b1;

    for (int k = 0; k < 8; k++) begin
      rst = vecs[k].rst; req_set_i = vecs[k].req;
      g0_ready_i = vecs[k].r0; g1_ready_i = vecs[k].r1;
      step();
      check($sformatf("vec%0d", k),
            {9'd0, pend_o, g0_valid_o, g0_idx_o, g1_valid_o, g1_idx_o, merged_o},
            {9'd0, vecs[k].e_pend, vecs[k].e_v0, vecs[k].e_i0, vecs[k].e_v1, vecs[k].e_i1, vecs[k].e_m});
    end

    // Stalled ch0 holds index 11 while ch1 serves index 8.
    g0_ready_i = 0; g1_ready_i = 1;
    req_set_i = 12'h800; step();
    req_set_i = 12'h000; step();
    check("stall_g0", {g0_valid_o, g0_idx_o}, {1'b1, 4'd11});
    step();
    check("stall_g0_hold", {g0_valid_o, g0_idx_o}, {1'b1, 4'd11});
    req_set_i = 12'h100; step();
    req_set_i = 12'h000; step();
    check("g1_idx8", {g1_valid_o, g1_idx_o}, {1'b1, 4'd8});
    check("g0_still11", {g0_valid_o, g0_idx_o}, {1'b1, 4'd11});
    g0_ready_i = 1; step();
    check("g0_release", g0_valid_o, 1'b0);

    // ch0 stalled on index 0, ch1 alone drains 0x030 as 5 then 4.
    g0_ready_i = 0;
    req_set_i = 12'h001; step();
    req_set_i = 12'h000; step();
    check("g0_hold0", {g0_valid_o, g0_idx_o}, {1'b1, 4'd0});
    req_set_i = 12'h030; step();
    req_set_i = 12'h000; step();
    check("g1_idx5", {g1_valid_o, g1_idx_o}, {1'b1, 4'd5});
    step();
    check("g1_idx4", {g1_valid_o, g1_idx_o}, {1'b1, 4'd4});
    step();
    check("g1_empty", {g1_valid_o, pend_o}, 13'd0);

    // Both channels occupied and stalled; a repeated set merges once.
    g1_ready_i = 0;
    req_set_i = 12'h002; step();
    req_set_i = 12'h000; step();
    check("g1_occ", {g1_valid_o, g1_idx_o}, {1'b1, 4'd1});
    req_set_i = 12'h004; step();
    check("merge_first", merged_o, 1'b0);
    req_set_i = 12'h004; step();
    check("merge_hit", merged_o, 1'b1);
    req_set_i = 12'h000; step();
    check("merge_once", merged_o, 1'b0);
    check("merge_pend", pend_o, 12'h004);
    g0_ready_i = 1; g1_ready_i = 1; step();
    check("merge_drain", {g0_valid_o, g0_idx_o, pend_o}, {1'b1, 4'd2, 12'h000});
    step();

    // Full vector drains in six pairs, highest first.
    req_set_i = 12'hFFF; step();
    req_set_i = 12'h000;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("drain%0d", k),
            {g0_valid_o, g0_idx_o, g1_valid_o, g1_idx_o, pend_o},
            {1'b1, 4'(11 - 2 * k), 1'b1, 4'(10 - 2 * k), 12'((1 << (10 - 2 * k)) - 1)});
    end
    step();
    check("drain_done", {g0_valid_o, g1_valid_o}, 2'b00);

    // Reset in the middle of a drain.
    req_set_i = 12'hFFF; step();
    req_set_i = 12'h000; step(); step(); step();
    rst = 1; req_set_i = 12'hFFF; step();
    check("midrst", {g0_valid_o, g1_valid_o, pend_o, merged_o}, 15'd0);
    rst = 0; req_set_i = 12'h000; step();
    check("midrst_after", {g0_valid_o, g1_valid_o, pend_o, merged_o}, 15'd0);

    // Randomised traffic against the model.
    for (int k = 0; k < 800; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req_set_i  = ($urandom_range(0, 3) == 0) ? 12'h000 : N'($urandom & $urandom & $urandom);
      g0_ready_i = ($urandom_range(0, 3) != 0);
      g1_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
